// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared AES helpers: byte/word substitution, rotation, xtime, FSM state type
package aes_pkg;

  localparam int NB = 4;

  typedef enum logic [1:0] {IDLE, EXPAND, READY} ks_state_e;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = xtime(aa);
    end
    return p;
  endfunction

  // Multiplicative inverse as x^254 through a fixed square/multiply chain; 0 maps to 0.
  function automatic logic [7:0] gf_inv(input logic [7:0] x);
    logic [7:0] x2, x3, x12, x15, x240;
    x2   = gf_mul(x, x);
    x3   = gf_mul(x2, x);
    x12  = gf_mul(gf_mul(x3, x3), gf_mul(x3, x3));
    x15  = gf_mul(x12, x3);
    x240 = gf_mul(x15, x15);
    x240 = gf_mul(x240, x240);
    x240 = gf_mul(x240, x240);
    x240 = gf_mul(x240, x240);
    return gf_mul(gf_mul(x240, x12), x2);
  endfunction

  function automatic logic [7:0] sbox_byte(input logic [7:0] x);
    logic [7:0] b;
    b = gf_inv(x);
    return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox_byte(w[31:24]), sbox_byte(w[23:16]), sbox_byte(w[15:8]), sbox_byte(w[7:0])};
  endfunction

  function automatic logic [31:0] rot_word(input logic [31:0] w);
    return {w[23:0], w[31:24]};
  endfunction

endpackage

// File: rtl/key_word_unit.sv
// rtl/key_word_unit.sv - combinational next schedule word from w[i-1], w[i-NK] and phase flags
module key_word_unit
  import aes_pkg::*;
(
  input  logic [31:0] w_prev,
  input  logic [31:0] w_back,
  input  logic [7:0]  rcon,
  input  logic        rot_phase,
  input  logic        sub_phase,
  output logic [31:0] w_new
);

  logic [31:0] t;

  always_comb begin
    t = w_prev;
    if (rot_phase) begin
      t = sub_word(rot_word(w_prev)) ^ {rcon, 24'h000000};
    end else if (sub_phase) begin
      t = sub_word(w_prev);
    end
    w_new = w_back ^ t;
  end

endmodule

// File: rtl/key_schedule_sequencer.sv
// rtl/key_schedule_sequencer.sv - iterative AES key schedule, one word per clock, round keys served
// from the word store as soon as their four words exist
module key_schedule_sequencer
  import aes_pkg::*;
#(
  parameter int NK = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [0:32*NK-1]  key,
  input  logic              key_valid,
  output logic              key_ready,
  output logic              busy,
  output logic              done,
  input  logic              rk_req,
  input  logic [3:0]        rk_idx,
  output logic              rk_valid,
  output logic [0:127]      rk_data,
  output logic              rk_err
);

  localparam int NR  = NK + 6;
  localparam int NW  = NB * (NR + 1);
  localparam int WCW = $clog2(NW + 1);
  localparam logic [3:0] NR_L = 4'(NR);

  if (!(NK == 4 || NK == 6 || NK == 8)) begin : g_bad_nk
    $error("key_schedule_sequencer: NK must be 4, 6 or 8");
  end

  ks_state_e        state_q, state_d;
  logic [WCW-1:0]   wcnt_q, wcnt_d;
  logic [2:0]       phase_q, phase_d;
  logic [7:0]       rcon_q, rcon_d;
  logic             key_ready_q, key_ready_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             rk_valid_q, rk_valid_d;
  logic             rk_err_q, rk_err_d;
  logic [0:127]     rk_data_q, rk_data_d;

  logic [31:0]      w_q [NW];

  logic             accept;
  logic [31:0]      w_new;
  logic [3:0]       rk_sel;
  logic [WCW-1:0]   rk_base;
  logic [6:0]       rk_need;
  logic             rk_avail;

  assign accept   = key_valid && key_ready_q;
  // Out-of-range indices are clamped so the store read never leaves the array.
  assign rk_sel   = (rk_idx > NR_L) ? NR_L : rk_idx;
  assign rk_base  = WCW'({rk_sel, 2'b00});
  assign rk_need  = {1'b0, rk_idx, 2'b00} + 7'd4;
  assign rk_avail = 7'(wcnt_q) >= rk_need;

  key_word_unit u_word (
    .w_prev    (w_q[wcnt_q - WCW'(1)]),
    .w_back    (w_q[wcnt_q - WCW'(NK)]),
    .rcon      (rcon_q),
    .rot_phase (phase_q == 3'd0),
    .sub_phase ((NK == 8) && (phase_q == 3'd4)),
    .w_new     (w_new)
  );

  always_comb begin
    state_d    = state_q;
    wcnt_d     = wcnt_q;
    phase_d    = phase_q;
    rcon_d     = rcon_q;
    done_d     = 1'b0;
    rk_valid_d = 1'b0;
    rk_err_d   = 1'b0;
    rk_data_d  = rk_data_q;

    if (accept) begin
      state_d = EXPAND;
      wcnt_d  = WCW'(NK);
      phase_d = 3'd0;
      rcon_d  = 8'h01;
    end else if (state_q == EXPAND) begin
      wcnt_d  = wcnt_q + WCW'(1);
      phase_d = (phase_q == 3'(NK - 1)) ? 3'd0 : phase_q + 3'd1;
      if (phase_q == 3'd0) rcon_d = xtime(rcon_q);
      if (wcnt_q == WCW'(NW - 1)) begin
        state_d = READY;
        done_d  = 1'b1;
      end
    end

    // A key accept restarts wcnt, so the old schedule must not answer in that cycle.
    if (rk_req && (rk_idx > NR_L)) begin
      rk_err_d = 1'b1;
    end else if (rk_req && !accept && (state_q != IDLE) && rk_avail) begin
      rk_valid_d = 1'b1;
      rk_data_d  = {w_q[rk_base], w_q[rk_base + WCW'(1)],
                    w_q[rk_base + WCW'(2)], w_q[rk_base + WCW'(3)]};
    end

    key_ready_d = (state_d != EXPAND);
    busy_d      = (state_d == EXPAND);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      wcnt_q      <= '0;
      phase_q     <= 3'd0;
      rcon_q      <= 8'h01;
      key_ready_q <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      rk_valid_q  <= 1'b0;
      rk_err_q    <= 1'b0;
      rk_data_q   <= '0;
    end else begin
      state_q     <= state_d;
      wcnt_q      <= wcnt_d;
      phase_q     <= phase_d;
      rcon_q      <= rcon_d;
      key_ready_q <= key_ready_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      rk_valid_q  <= rk_valid_d;
      rk_err_q    <= rk_err_d;
      rk_data_q   <= rk_data_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      if (accept) begin
        for (int j = 0; j < NK; j++) w_q[j] <= key[32*j +: 32];
      end else if (state_q == EXPAND) begin
        w_q[wcnt_q] <= w_new;
      end
    end
  end

  assign key_ready = key_ready_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign rk_valid  = rk_valid_q;
  assign rk_data   = rk_data_q;
  assign rk_err    = rk_err_q;

endmodule

// File: tb/tb_key_schedule_sequencer.sv
// tb/tb_key_schedule_sequencer.sv - self-checking bench for key_schedule_sequencer, NK=4/6/8 instances
module tb_key_schedule_sequencer;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic         kv    [3];
  logic [0:255] key_a [3];
  logic         req   [3];
  logic [3:0]   idx   [3];
  logic         kr    [3];
  logic         bsy   [3];
  logic         dn    [3];
  logic         rv    [3];
  logic         re    [3];
  logic [0:127] rd    [3];

  int total = 0;
  int bad   = 0;
  logic [127:0] exp_q [$];
  logic [7:0]   sb [256];
  logic [31:0]  mw [3][60];

  key_schedule_sequencer #(.NK(4)) u4 (
    .clk(clk), .rst(rst), .key(key_a[0][0:127]), .key_valid(kv[0]), .key_ready(kr[0]),
    .busy(bsy[0]), .done(dn[0]), .rk_req(req[0]), .rk_idx(idx[0]), .rk_valid(rv[0]),
    .rk_data(rd[0]), .rk_err(re[0]));

  key_schedule_sequencer #(.NK(6)) u6 (
    .clk(clk), .rst(rst), .key(key_a[1][0:191]), .key_valid(kv[1]), .key_ready(kr[1]),
    .busy(bsy[1]), .done(dn[1]), .rk_req(req[1]), .rk_idx(idx[1]), .rk_valid(rv[1]),
    .rk_data(rd[1]), .rk_err(re[1]));

  key_schedule_sequencer #(.NK(8)) u8 (
    .clk(clk), .rst(rst), .key(key_a[2]), .key_valid(kv[2]), .key_ready(kr[2]),
    .busy(bsy[2]), .done(dn[2]), .rk_req(req[2]), .rk_idx(idx[2]), .rk_valid(rv[2]),
    .rk_data(rd[2]), .rk_err(re[2]));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] bxt(input logic [7:0] b);
    logic [8:0] s;
    s = {b, 1'b0};
    if (s[8]) s = s ^ 9'h11b;
    return s[7:0];
  endfunction

  // Reference S-box from exp/log tables over generator 3 plus the bitwise affine map.
  task automatic build_sbox();
    logic [7:0] ex [256];
    int         lg [256];
    logic [7:0] x, inv, s, c;
    x = 8'h01;
    for (int i = 0; i < 255; i++) begin
      ex[i] = x;
      lg[x] = i;
      x = x ^ bxt(x);
    end
    c = 8'h63;
    for (int a = 0; a < 256; a++) begin
      inv = (a == 0) ? 8'h00 : ex[(255 - lg[a]) % 255];
      for (int i = 0; i < 8; i++)
        s[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8] ^ c[i];
      sb[a] = s;
    end
  endtask

  function automatic logic [31:0] bsub(input logic [31:0] w);
    return {sb[w[31:24]], sb[w[23:16]], sb[w[15:8]], sb[w[7:0]]};
  endfunction

  task automatic model_expand(input int inst, input int nk, input logic [0:255] k);
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < nk; i++) mw[inst][i] = k[32*i +: 32];
    for (int i = nk; i < 4*(nk+7); i++) begin
      t = mw[inst][i-1];
      if (i % nk == 0) begin
        t  = bsub({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = bxt(rc);
      end else if (nk > 6 && i % nk == 4) begin
        t = bsub(t);
      end
      mw[inst][i] = mw[inst][i-nk] ^ t;
    end
  endtask

  function automatic logic [127:0] mround(input int inst, input int r);
    return {mw[inst][4*r], mw[inst][4*r+1], mw[inst][4*r+2], mw[inst][4*r+3]};
  endfunction

  task automatic accept(input int inst, input logic [0:255] kin);
    total++;
    if (kr[inst] !== 1'b1) begin
      bad++;
      $display("FAIL key_ready_before_accept inst=%0d got=%b exp=1", inst, kr[inst]);
    end
    key_a[inst] = kin;
    kv[inst] = 1'b1;
    tick();
    kv[inst] = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    for (int i = 0; i < 3; i++) begin
      total += 6;
      if (kr[i] !== 1'b1) begin bad++; $display("FAIL reset_key_ready inst=%0d got=%b exp=1", i, kr[i]); end
      if (bsy[i] !== 1'b0) begin bad++; $display("FAIL reset_busy inst=%0d got=%b exp=0", i, bsy[i]); end
      if (dn[i] !== 1'b0) begin bad++; $display("FAIL reset_done inst=%0d got=%b exp=0", i, dn[i]); end
      if (rv[i] !== 1'b0) begin bad++; $display("FAIL reset_rk_valid inst=%0d got=%b exp=0", i, rv[i]); end
      if (re[i] !== 1'b0) begin bad++; $display("FAIL reset_rk_err inst=%0d got=%b exp=0", i, re[i]); end
      if (rd[i] !== 128'h0) begin bad++; $display("FAIL reset_rk_data inst=%0d got=%h exp=0", i, rd[i]); end
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_expand(input int inst, input int nk, input logic [0:255] kin, input int wi,
                             input logic [31:0] wexp, input logic [127:0] rexp);
    int nr, nw, c;
    logic [127:0] e, got, held;
    nr = nk + 6;
    nw = 4 * (nr + 1);
    exp_q.delete();
    model_expand(inst, nk, kin);
    accept(inst, kin);
    total += 2;
    if (bsy[inst] !== 1'b1) begin bad++; $display("FAIL expand_busy nk=%0d got=%b exp=1", nk, bsy[inst]); end
    if (kr[inst] !== 1'b0) begin bad++; $display("FAIL expand_key_ready nk=%0d got=%b exp=0", nk, kr[inst]); end
    c = 0;
    while (dn[inst] !== 1'b1 && c < 200) begin
      tick();
      c++;
    end
    total++;
    if (c !== nw - nk) begin bad++; $display("FAIL done_latency nk=%0d got=%0d exp=%0d", nk, c, nw - nk); end
    tick();
    total += 3;
    if (dn[inst] !== 1'b0) begin bad++; $display("FAIL done_pulse nk=%0d got=%b exp=0", nk, dn[inst]); end
    if (kr[inst] !== 1'b1) begin bad++; $display("FAIL ready_key_ready nk=%0d got=%b exp=1", nk, kr[inst]); end
    if (bsy[inst] !== 1'b0) begin bad++; $display("FAIL ready_busy nk=%0d got=%b exp=0", nk, bsy[inst]); end
    req[inst] = 1'b1;
    for (int r = 0; r <= nr; r++) begin
      idx[inst] = 4'(r);
      exp_q.push_back(mround(inst, r));
      tick();
      total++;
      if (rv[inst] !== 1'b1 || exp_q.size() == 0) begin
        bad++;
        $display("FAIL b2b_rk_valid nk=%0d round=%0d got=%b exp=1", nk, r, rv[inst]);
      end else begin
        e = exp_q.pop_front();
        got = rd[inst];
        total++;
        if (got !== e) begin bad++; $display("FAIL b2b_rk_data nk=%0d round=%0d got=%h exp=%h", nk, r, got, e); end
        if (r == wi / 4) begin
          total++;
          if (got[127 - 32*(wi%4) -: 32] !== wexp) begin
            bad++;
            $display("FAIL first_expanded_word nk=%0d got=%h exp=%h", nk, got[127 - 32*(wi%4) -: 32], wexp);
          end
        end
        if (r == nr) begin
          total++;
          if (got !== rexp) begin bad++; $display("FAIL last_round nk=%0d got=%h exp=%h", nk, got, rexp); end
        end
      end
    end
    req[inst] = 1'b0;
    held = rexp;
    tick();
    total += 2;
    if (rv[inst] !== 1'b0) begin bad++; $display("FAIL idle_rk_valid nk=%0d got=%b exp=0", nk, rv[inst]); end
    if (rd[inst] !== held) begin bad++; $display("FAIL rk_data_hold nk=%0d got=%h exp=%h", nk, rd[inst], held); end
  endtask

  task automatic test_early_fetch();
    logic [0:255] kin;
    logic [127:0] e;
    int c;
    exp_q.delete();
    kin = {$urandom(), $urandom(), $urandom(), $urandom(), 128'h0};
    model_expand(0, 4, kin);
    accept(0, kin);
    req[0] = 1'b1;
    idx[0] = 4'd2;
    exp_q.push_back(mround(0, 2));
    c = 0;
    while (rv[0] !== 1'b1 && c < 60) begin
      tick();
      c++;
    end
    total++;
    if (c !== 9) begin bad++; $display("FAIL early_fetch_latency got=%0d exp=9", c); end
    if (rv[0] === 1'b1 && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      total++;
      if (rd[0] !== e) begin bad++; $display("FAIL early_fetch_data got=%h exp=%h", rd[0], e); end
    end
    idx[0] = 4'd11;
    tick();
    total += 2;
    if (re[0] !== 1'b1) begin bad++; $display("FAIL bad_idx_rk_err got=%b exp=1", re[0]); end
    if (rv[0] !== 1'b0) begin bad++; $display("FAIL bad_idx_rk_valid got=%b exp=0", rv[0]); end
    req[0] = 1'b0;
    tick();
    total++;
    if (re[0] !== 1'b0) begin bad++; $display("FAIL rk_err_pulse got=%b exp=0", re[0]); end
    c = 0;
    while (dn[0] !== 1'b1 && c < 60) begin
      tick();
      c++;
    end
    total++;
    if (dn[0] !== 1'b1) begin bad++; $display("FAIL early_fetch_done got=%b exp=1", dn[0]); end
    tick();
  endtask

  task automatic test_new_key_in_ready();
    logic [0:255] kin;
    logic [127:0] e;
    int c;
    exp_q.delete();
    kin = {$urandom(), $urandom(), $urandom(), $urandom(), 128'h0};
    model_expand(0, 4, kin);
    key_a[0] = kin;
    kv[0] = 1'b1;
    req[0] = 1'b1;
    idx[0] = 4'd0;
    tick();
    kv[0] = 1'b0;
    total += 2;
    if (rv[0] !== 1'b0) begin bad++; $display("FAIL accept_cycle_rk_valid got=%b exp=0", rv[0]); end
    if (bsy[0] !== 1'b1) begin bad++; $display("FAIL new_key_busy got=%b exp=1", bsy[0]); end
    exp_q.push_back(mround(0, 0));
    tick();
    total++;
    if (rv[0] !== 1'b1) begin
      bad++;
      $display("FAIL new_key_round0_valid got=%b exp=1", rv[0]);
    end else begin
      e = exp_q.pop_front();
      total++;
      if (rd[0] !== e) begin bad++; $display("FAIL new_key_round0_data got=%h exp=%h", rd[0], e); end
    end
    req[0] = 1'b0;
    c = 0;
    while (dn[0] !== 1'b1 && c < 60) begin
      tick();
      c++;
    end
    exp_q.delete();
    req[0] = 1'b1;
    idx[0] = 4'd10;
    exp_q.push_back(mround(0, 10));
    tick();
    req[0] = 1'b0;
    total++;
    if (rv[0] !== 1'b1) begin
      bad++;
      $display("FAIL new_key_round10_valid got=%b exp=1", rv[0]);
    end else begin
      e = exp_q.pop_front();
      total++;
      if (rd[0] !== e) begin bad++; $display("FAIL new_key_round10_data got=%h exp=%h", rd[0], e); end
    end
    tick();
  endtask

  task automatic test_reset_mid_expand();
    logic [0:255] kin;
    logic [127:0] e;
    int cnt;
    exp_q.delete();
    kin = {$urandom(), $urandom(), $urandom(), $urandom(), 128'h0};
    accept(0, kin);
    repeat (19) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    total += 3;
    if (kr[0] !== 1'b1) begin bad++; $display("FAIL mid_reset_key_ready got=%b exp=1", kr[0]); end
    if (bsy[0] !== 1'b0) begin bad++; $display("FAIL mid_reset_busy got=%b exp=0", bsy[0]); end
    if (dn[0] !== 1'b0) begin bad++; $display("FAIL mid_reset_done got=%b exp=0", dn[0]); end
    req[0] = 1'b1;
    idx[0] = 4'd0;
    cnt = 0;
    repeat (6) begin
      tick();
      if (rv[0] === 1'b1) cnt++;
    end
    req[0] = 1'b0;
    total++;
    if (cnt !== 0) begin bad++; $display("FAIL idle_request_served got=%0d exp=0", cnt); end
    kin = {$urandom(), $urandom(), $urandom(), $urandom(), 128'h0};
    model_expand(0, 4, kin);
    accept(0, kin);
    req[0] = 1'b1;
    exp_q.push_back(mround(0, 0));
    tick();
    req[0] = 1'b0;
    total++;
    if (rv[0] !== 1'b1) begin
      bad++;
      $display("FAIL after_reset_round0_valid got=%b exp=1", rv[0]);
    end else begin
      e = exp_q.pop_front();
      total++;
      if (rd[0] !== e) begin bad++; $display("FAIL after_reset_round0_data got=%h exp=%h", rd[0], e); end
    end
    tick();
  endtask

  initial begin
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      kv[i]    = 1'b0;
      req[i]   = 1'b0;
      idx[i]   = 4'd0;
      key_a[i] = '0;
    end
    build_sbox();
    test_reset();
    test_expand(0, 4, {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0},
                4, 32'ha0fafe17, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    test_expand(1, 6, {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0},
                6, 32'hfe0c91f7, 128'he98ba06f448c773c8ecc720401002202);
    test_expand(2, 8, 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4,
                8, 32'h9ba35411, 128'hfe4890d1e6188d0b046df344706c631e);
    test_early_fetch();
    test_new_key_in_ready();
    test_reset_mid_expand();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
